// File: rtl/comp_img_pkg.sv
// Shared definitions for the compressed image reader.
// Holds the compressed-image geometry, the pixel type and the read FSM
// state encoding used by compressed_image_reader and its FIFO.
package comp_img_pkg;

    localparam int IMG_W     = 28;
    localparam int IMG_H     = 28;
    localparam int NPIX      = IMG_W * IMG_H;
    localparam int PIX_W     = 8;
    localparam int ADDR_W    = 10;
    localparam int LAST_ADDR = NPIX - 1;

    typedef logic [PIX_W-1:0] pix_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } rd_state_t;

endpackage

// File: rtl/comp_rd_fifo.sv
// Small synchronous FIFO between the SRAM read port and the pixel stream.
// Carries pixel data only; row/column tags are produced on the output side.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset
//   push         write push_data this cycle
//   push_data    data to store
//   pop          consumer accepts the head entry (ignored when empty)
//   pop_data     head entry, held until popped
//   not_empty    registered non-empty flag (drives pix_valid)
//   count        registered occupancy, used for read credit
module comp_rd_fifo #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               pop_data,
    output logic                           not_empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_next;
    logic             do_push;
    logic             do_pop;

    // A pop frees its slot in the same cycle, so a full FIFO may still
    // accept a push when the head is being consumed.
    assign do_pop   = pop && not_empty;
    assign do_push  = push && ((count != CW'(DEPTH)) || do_pop);
    assign pop_data = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            not_empty <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            count     <= count_next;
            not_empty <= (count_next != '0);
        end
    end

endmodule

// File: rtl/compressed_image_reader.sv
// Streams the 28x28 compressed image out of on-chip SRAM in row-major order
// over a valid/ready interface, keeping SRAM reads back-to-back and absorbing
// read latency and back-pressure in a RD_LAT+2 deep FIFO.
// Ports:
//   clk, rst_n               clock and asynchronous active-low reset
//   start                    one-cycle pulse starting a frame (ignored unless idle)
//   busy, done               frame in progress / one-cycle end-of-frame pulse
//   sram_rd_en/addr/data     SRAM read port, data returns RD_LAT cycles after enable
//   pix_out/row/col/last     streamed pixel with its position and last-pixel flag
//   pix_valid, pix_ready     output handshake
// Build option: define COMP_RD_INVERT_EN to output 255 - pixel (white-on-black).
module compressed_image_reader
    import comp_img_pkg::*;
#(
    parameter int IMG_W  = comp_img_pkg::IMG_W,
    parameter int IMG_H  = comp_img_pkg::IMG_H,
    parameter int PIX_W  = comp_img_pkg::PIX_W,
    parameter int ADDR_W = comp_img_pkg::ADDR_W,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              sram_rd_en,
    output logic [ADDR_W-1:0] sram_rd_addr,
    input  logic [PIX_W-1:0]  sram_rd_data,
    output logic [PIX_W-1:0]  pix_out,
    output logic [4:0]        pix_row,
    output logic [4:0]        pix_col,
    output logic              pix_last,
    output logic              pix_valid,
    input  logic              pix_ready
);

    localparam int DEPTH = RD_LAT + 2;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(IMG_W * IMG_H - 1);

    rd_state_t        state;
    logic [RD_LAT-1:0] en_pipe;
    logic [CW-1:0]    fifo_count;
    logic [3:0]       inflight;
    logic [3:0]       credit_used;
    logic             fifo_push;
    logic             handshake;
    logic [PIX_W-1:0] fifo_data;

    // Reads in flight are the enables still travelling through the latency
    // pipe. Credit uses the registered occupancy only, with no allowance for
    // a pop happening in the same cycle.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + 4'(en_pipe[i]);
        end
        credit_used = 4'(fifo_count) + inflight;
    end

    assign sram_rd_en = (state == READ) && (credit_used < 4'(DEPTH));
    assign fifo_push  = en_pipe[RD_LAT-1];
    assign handshake  = pix_valid && pix_ready;
    assign pix_last   = (pix_row == 5'(IMG_H - 1)) && (pix_col == 5'(IMG_W - 1));

    // Frame sequencing: READ issues addresses 0..LAST, DRAIN waits for the
    // final handshake, done pulses the cycle after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            sram_rd_addr <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= READ;
                        sram_rd_addr <= '0;
                        busy         <= 1'b1;
                    end
                end
                READ: begin
                    if (sram_rd_en) begin
                        if (sram_rd_addr == LAST) begin
                            state <= DRAIN;
                        end else begin
                            sram_rd_addr <= sram_rd_addr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (handshake && pix_last) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Delays each read enable by RD_LAT cycles so the push lines up with the
    // SRAM returning that read's data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_pipe <= '0;
        end else begin
            en_pipe <= RD_LAT'({en_pipe, sram_rd_en});
        end
    end

    // Output position counter; advances only on handshake and wraps to 0,0
    // after the last pixel so the next frame starts clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_row <= '0;
            pix_col <= '0;
        end else if (handshake) begin
            if (pix_col == 5'(IMG_W - 1)) begin
                pix_col <= '0;
                pix_row <= (pix_row == 5'(IMG_H - 1)) ? '0 : pix_row + 1'b1;
            end else begin
                pix_col <= pix_col + 1'b1;
            end
        end
    end

    comp_rd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (sram_rd_data),
        .pop       (pix_ready),
        .pop_data  (fifo_data),
        .not_empty (pix_valid),
        .count     (fifo_count)
    );

`ifdef COMP_RD_INVERT_EN
    // Inverted output is gated by valid so the idle/reset output stays 0.
    assign pix_out = pix_valid ? ({PIX_W{1'b1}} - fifo_data) : '0;
`else
    assign pix_out = fifo_data;
`endif

endmodule

// File: tb/tb_compressed_image_reader.sv
// Self-checking bench for compressed_image_reader: a scoreboard of expected
// pixels per frame plus per-scenario tasks, and a second RD_LAT=2 instance.
module tb_compressed_image_reader;

    localparam int DEPTH = 3;   // RD_LAT=1 instance: RD_LAT+2

    typedef struct packed {
        logic [7:0] pix;
        logic [4:0] row;
        logic [4:0] col;
        logic       last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, start, pix_ready;
    logic       busy, done, sram_rd_en, pix_last, pix_valid;
    logic [9:0] sram_rd_addr;
    logic [7:0] sram_rd_data, pix_out;
    logic [4:0] pix_row, pix_col;

    logic       start2, ready2;
    logic       busy2, done2, en2, last2, valid2;
    logic [9:0] addr2;
    logic [7:0] data2, data2_a, pix2;
    logic [4:0] row2, col2;

    logic [7:0] sram [1024];
    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         exp_addr = 0;
    int         outstanding = 0;
    bit         prev_stall = 0;
    exp_t       held;

    always #20 clk = ~clk;

    compressed_image_reader #(.RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data),
        .pix_out(pix_out), .pix_row(pix_row), .pix_col(pix_col), .pix_last(pix_last),
        .pix_valid(pix_valid), .pix_ready(pix_ready)
    );

    compressed_image_reader #(.RD_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .busy(busy2), .done(done2),
        .sram_rd_en(en2), .sram_rd_addr(addr2), .sram_rd_data(data2),
        .pix_out(pix2), .pix_row(row2), .pix_col(col2), .pix_last(last2),
        .pix_valid(valid2), .pix_ready(ready2)
    );

    // SRAM models: one and two cycles of read latency
    always @(posedge clk) begin
        sram_rd_data <= sram[sram_rd_addr];
        data2_a      <= sram[addr2];
        data2        <= data2_a;
    end

    function automatic logic [7:0] exp_pix(input logic [7:0] v);
`ifdef COMP_RD_INVERT_EN
        return 8'hFF - v;
`else
        return v;
`endif
    endfunction

    // Monitor: address order, credit bound, output stability and scoreboard
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (sram_rd_en) begin
                checks++;
                if (sram_rd_addr !== 10'(exp_addr)) begin
                    errors++;
                    $display("[TB] FAIL rd_addr: got %0d, expected %0d", sram_rd_addr, exp_addr);
                end
                checks++;
                if (outstanding + 1 > DEPTH) begin
                    errors++;
                    $display("[TB] FAIL credit: %0d outstanding reads, limit %0d", outstanding + 1, DEPTH);
                end
                exp_addr++;
                outstanding++;
            end
            if (prev_stall) begin
                checks++;
                if (!pix_valid || {pix_out, pix_row, pix_col, pix_last} !== held) begin
                    errors++;
                    $display("[TB] FAIL stable: got valid=%b %h, expected valid=1 %h",
                             pix_valid, {pix_out, pix_row, pix_col, pix_last}, held);
                end
            end
            prev_stall = pix_valid && !pix_ready;
            held = {pix_out, pix_row, pix_col, pix_last};
            if (pix_valid && pix_ready) begin
                outstanding--;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL pixel: got unexpected pix=%0d, expected no output", pix_out);
                end else begin
                    e = sb.pop_front();
                    if ({pix_out, pix_row, pix_col, pix_last} !== e) begin
                        errors++;
                        $display("[TB] FAIL pixel: got pix=%0d row=%0d col=%0d last=%b, expected pix=%0d row=%0d col=%0d last=%b",
                                 pix_out, pix_row, pix_col, pix_last, e.pix, e.row, e.col, e.last);
                    end
                end
            end
        end
    end

    task automatic sb_fill();
        sb.delete();
        for (int n = 0; n < 784; n++) begin
            sb.push_back({exp_pix(sram[n]), 5'(n / 28), 5'(n % 28), (n == 783)});
        end
        exp_addr    = 0;
        outstanding = 0;
        prev_stall  = 0;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Runs the stream from cycle 1 of a frame until done, an abort point or a
    // cycle budget; only collects observations for the caller to judge.
    task automatic run_frame(input bit rand_ready, input int restart_at, input int abort_at,
                             output int hs, output int first_valid, output int last_cyc,
                             output int done_cyc, output int gaps, output bit timed_out);
        int  cyc;
        bit  seen_last;
        hs = 0; first_valid = -1; last_cyc = -1; done_cyc = -1; gaps = 0;
        timed_out = 0; seen_last = 0; cyc = 1;
        forever begin
            @(negedge clk);
            if (pix_valid && first_valid < 0) first_valid = cyc;
            if (first_valid >= 0 && !seen_last && !pix_valid) gaps++;
            if (pix_valid && pix_ready) begin
                hs++;
                if (pix_last) begin
                    seen_last = 1;
                    last_cyc  = cyc;
                end
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (abort_at > 0 && hs >= abort_at) break;
            if (cyc >= 6000) begin
                timed_out = 1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
            if (rand_ready) pix_ready = 1'($urandom_range(0, 1));
            start = (restart_at > 0 && hs == restart_at);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; pix_ready = 1'b0; start2 = 1'b0; ready2 = 1'b0;
        #50;
        checks++;
        if ({busy, done, sram_rd_en, pix_valid, pix_last, sram_rd_addr, pix_out, pix_row, pix_col} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got busy=%b done=%b en=%b valid=%b last=%b addr=%0d pix=%0d row=%0d col=%0d, expected all 0",
                     busy, done, sram_rd_en, pix_valid, pix_last, sram_rd_addr, pix_out, pix_row, pix_col);
        end
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int hs, fv, lc, dc, gaps;
        bit to;
        pix_ready = 1'b1;
        sb_fill();
        pulse_start();
        checks++;
        if (!sram_rd_en || sram_rd_addr !== 10'd0 || !busy || pix_valid) begin
            errors++;
            $display("[TB] FAIL first_read: got en=%b addr=%0d busy=%b valid=%b, expected en=1 addr=0 busy=1 valid=0",
                     sram_rd_en, sram_rd_addr, busy, pix_valid);
        end
        run_frame(0, 0, 0, hs, fv, lc, dc, gaps, to);
        checks++;
        if (to || hs != 784) begin
            errors++;
            $display("[TB] FAIL basic_count: got %0d handshakes timeout=%b, expected 784", hs, to);
        end
        checks++;
        if (fv != 3) begin
            errors++;
            $display("[TB] FAIL first_valid: got cycle %0d, expected 3", fv);
        end
        checks++;
        if (gaps != 0 || lc != 786) begin
            errors++;
            $display("[TB] FAIL throughput: got %0d gaps last at cycle %0d, expected 0 gaps last at 786", gaps, lc);
        end
        checks++;
        if (dc != lc + 1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL done_pulse: got done at %0d busy=%b, expected done at %0d busy=0", dc, busy, lc + 1);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL done_width: got done=%b queue=%0d, expected done=0 queue=0", done, sb.size());
        end
    endtask

    task automatic test_random_ready();
        int hs, fv, lc, dc, gaps;
        bit to;
        sb_fill();
        pulse_start();
        run_frame(1, 0, 0, hs, fv, lc, dc, gaps, to);
        pix_ready = 1'b1;
        checks++;
        if (to || hs != 784 || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL random_ready: got %0d handshakes queue=%0d timeout=%b, expected 784 and 0", hs, sb.size(), to);
        end
    endtask

    task automatic test_backpressure();
        int hs, fv, lc, dc, gaps, reads;
        bit to;
        pix_ready = 1'b0;
        reads = 0;
        sb_fill();
        pulse_start();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sram_rd_en) reads++;
            @(posedge clk); #1;
        end
        checks++;
        if (reads < 1 || reads > DEPTH) begin
            errors++;
            $display("[TB] FAIL stall_reads: got %0d reads, expected 1..%0d", reads, DEPTH);
        end
        checks++;
        if (!pix_valid || pix_out !== exp_pix(sram[0])) begin
            errors++;
            $display("[TB] FAIL stall_head: got valid=%b pix=%0d, expected valid=1 pix=%0d", pix_valid, pix_out, exp_pix(sram[0]));
        end
        pix_ready = 1'b1;
        run_frame(0, 0, 0, hs, fv, lc, dc, gaps, to);
        checks++;
        if (to || hs != 784 || gaps != 0) begin
            errors++;
            $display("[TB] FAIL resume: got %0d handshakes %0d gaps timeout=%b, expected 784 and 0", hs, gaps, to);
        end
    endtask

    task automatic test_back_to_back();
        int hs, fv, lc, dc, gaps;
        bit to;
        pix_ready = 1'b1;
        sram[5] = 8'h10;
        sb_fill();
        pulse_start();
        run_frame(0, 100, 0, hs, fv, lc, dc, gaps, to);
        checks++;
        if (to || hs != 784 || dc < 0) begin
            errors++;
            $display("[TB] FAIL restart_ignored: got %0d handshakes done_cycle=%0d, expected 784 and done", hs, dc);
        end
        sram[5] = 8'd5;
        sb_fill();
        pulse_start();
        run_frame(0, 0, 0, hs, fv, lc, dc, gaps, to);
        checks++;
        if (to || hs != 784 || fv != 3 || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL second_frame: got %0d handshakes first_valid=%0d, expected 784 and 3", hs, fv);
        end
    endtask

    task automatic test_abort();
        int hs, fv, lc, dc, gaps;
        bit to;
        pix_ready = 1'b1;
        sb_fill();
        pulse_start();
        run_frame(0, 0, 400, hs, fv, lc, dc, gaps, to);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, sram_rd_en, pix_valid, pix_last, sram_rd_addr, pix_out, pix_row, pix_col} !== '0) begin
            errors++;
            $display("[TB] FAIL abort_outputs: got busy=%b en=%b valid=%b addr=%0d pix=%0d row=%0d col=%0d, expected all 0",
                     busy, sram_rd_en, pix_valid, sram_rd_addr, pix_out, pix_row, pix_col);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        sb_fill();
        pulse_start();
        run_frame(0, 0, 0, hs, fv, lc, dc, gaps, to);
        checks++;
        if (to || hs != 784 || fv != 3 || sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL fresh_frame: got %0d handshakes first_valid=%0d, expected 784 and 3", hs, fv);
        end
    endtask

    task automatic test_rd_lat2();
        int n, cyc, fv, dc;
        n = 0; cyc = 1; fv = -1; dc = -1;
        ready2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        while (cyc < 3000) begin
            @(negedge clk);
            if (valid2 && fv < 0) fv = cyc;
            if (valid2 && ready2) begin
                checks++;
                if ({pix2, row2, col2, last2} !== {exp_pix(8'(n)), 5'(n / 28), 5'(n % 28), n == 783}) begin
                    errors++;
                    $display("[TB] FAIL lat2_pixel %0d: got pix=%0d row=%0d col=%0d last=%b, expected pix=%0d",
                             n, pix2, row2, col2, last2, exp_pix(8'(n)));
                end
                n++;
            end
            if (done2) begin
                dc = cyc;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (n != 784 || fv != 4 || dc != 788) begin
            errors++;
            $display("[TB] FAIL lat2_timing: got %0d pixels first_valid=%0d done=%0d, expected 784, 4, 788", n, fv, dc);
        end
    endtask

    initial begin
        for (int a = 0; a < 1024; a++) sram[a] = 8'(a);
        test_reset();
        test_basic();
        test_random_ready();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_rd_lat2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/compressed_image_reader.md
Name: compressed_image_reader

Overview:
- Reads the 28*28 8-bit compressed image back out of the on-chip SRAM that the compressor fills.
- Streams the pixels in row-major order (address 0 to 783) over a valid/ready interface to the downstream recognition datapath.
- Keeps SRAM reads running back-to-back and absorbs read latency and downstream back-pressure in a small output FIFO, so the stream sustains one pixel per cycle.

Parameters:
- IMG_W, 28: compressed image columns.
- IMG_H, 28: compressed image rows.
- PIX_W, 8: pixel width in bits.
- ADDR_W, 10: SRAM address width.
- RD_LAT, 1: SRAM read latency in cycles. Legal values are 1 or 2.

Ports:
- clk  input  1  system clock (25MHz).
- rst_n  input  1  reset.
- start  input  1  one-cycle pulse; begins a frame read.
- busy  output  1  high from the cycle after start until done.
- done  output  1  one-cycle pulse after the last pixel handshake.
- sram_rd_en  output  1  SRAM read enable.
- sram_rd_addr  output  ADDR_W  SRAM read address, 0 to 783.
- sram_rd_data  input  PIX_W  SRAM read data, valid RD_LAT cycles after sram_rd_en.
- pix_out  output  PIX_W  streamed pixel.
- pix_row  output  5  row of pix_out, 0 to 27.
- pix_col  output  5  column of pix_out, 0 to 27.
- pix_last  output  1  high with pixel 783.
- pix_valid  output  1  pix_out is valid.
- pix_ready  input  1  downstream accepts.

Interface:
- One clock, clk.
- Reset is rst_n: asynchronous, active-low.
- Every flop resets to zero.

Behaviour:
- Reset values: busy, done, sram_rd_en, pix_valid and pix_last are 0. sram_rd_addr, pix_out, pix_row and pix_col are 0. FIFO is empty; state is IDLE.
- FSM states:
  - IDLE: start moves to READ.
  - READ: issues reads. Moves to DRAIN in the cycle the read of address 783 issues.
  - DRAIN: waits for the handshake of pixel 783, then returns to IDLE and pulses done one cycle later.
- start outside IDLE is ignored.
- Read address counter runs 0 to 783 with no wrap. It clears to 0 on entry to READ.
- FIFO:
  - Depth is RD_LAT+2.
  - A read issues only when (FIFO occupancy + reads in flight) < RD_LAT+2. Occupancy is the current registered value; there is no credit for a same-cycle pop.
  - Under this rule the FIFO never overflows, and with pix_ready held high the stream runs at 1 pixel/cycle.
- SRAM data is pushed into the FIFO exactly RD_LAT cycles after the matching sram_rd_en.
- Push and pop in the same cycle are legal, including when the FIFO is full, where pop frees the slot.
- pix_valid is the FIFO-not-empty flag, driven from a flop.
- Handshake occurs when pix_valid and pix_ready are both high.
- Once pix_valid is asserted, pix_out, pix_row, pix_col and pix_last hold stable until the handshake.
- pix_row and pix_col come from an output-side counter that advances only on handshake. The column wraps 27 to 0 and increments the row. pix_last = (row==27 && col==27).
- Latency, RD_LAT=1: start in cycle 0; sram_rd_en with address 0 in cycle 1; pix_valid for pixel 0 in cycle 3.
- Back-pressure: if pix_ready stays low, reads stall once the credit limit is reached. There is no loss or duplication, and addresses resume in order.
- busy is high in READ and DRAIN.
- done is high exactly one cycle, the cycle after the pixel-783 handshake.
- Asserting rst_n mid-frame aborts the frame immediately. Any in-flight read data is discarded.
- Exactly 784 handshakes occur per start.

Optional Feature:
- Macro: COMP_RD_INVERT_EN.
- Defined: pix_out = 255 - stored pixel, applied at the FIFO output as combinational logic, so the polarity matches MNIST-style white-on-black.
- Undefined: pix_out = stored pixel unchanged.
- Timing and handshake are identical in both builds.

Decomposition:
- Package comp_img_pkg holds:
  - constants IMG_W=28, IMG_H=28, NPIX=784, PIX_W=8, ADDR_W=10, LAST_ADDR=783;
  - typedef pix_t;
  - enum rd_state_t {IDLE, READ, DRAIN}.
- Sub-module comp_rd_fifo: synchronous FIFO parameterized on depth and width. It carries pixel data only; row and column come from the output counter.

Test Plan:
- SRAM model preloaded with mem[a]=a[7:0], pix_ready=1, one start pulse -> 784 pixels with pix_out[n]=n mod 256; first pix_valid in cycle 3; pixels back-to-back with no gaps; pix_last only on n=783 with row=27, col=27; done pulses 1 cycle after that handshake; busy then falls.
- Random pix_ready (50%) -> identical in-order sequence; outputs stable while valid and not ready; no FIFO overflow assertion fires; exactly 784 handshakes.
- pix_ready held 0 for 20 cycles after start -> at most RD_LAT+2 reads issued; after release the stream resumes at address RD_LAT+2 without gaps.
- start re-pulsed at pixel 100 -> ignored, the stream is unaffected. Start pulsed immediately after done -> a second full frame starts with row=0, col=0.
- rst_n asserted at pixel 400 -> all outputs 0 asynchronously. A new start afterwards gives a fresh frame from address 0; no stale data appears.
- COMP_RD_INVERT_EN defined with mem[5]=8'h10 -> pixel 5 output is 8'hEF; timing matches the non-inverting build; repeat the first test with RD_LAT=2.
